// File: rtl/count_display_driver.sv
// Binary-to-decimal display driver: change-triggered iterative double-dabble
// feeding a multiplexed 7-segment scanner with leading-zero blanking.
module count_display_driver #(
   parameter int N        = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      q,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              busy
);

   localparam int IW   = (N > 1) ? $clog2(N) : 1;
   localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int XW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW   = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        r_state;
   logic [N-1:0]  r_shreg;
   logic [BW-1:0] r_bcd;
   logic [BW-1:0] r_bcd_disp;
   logic [N-1:0]  r_last_q;
   logic [IW-1:0] r_iter;
   logic          r_force;
   logic [DW-1:0] r_div;
   logic [XW-1:0] r_idx;

   logic [BW-1:0]     w_bcd_adj;
   logic [DIGITS-1:0] w_zero_hi;
   logic [3:0]        w_nib;
   logic              w_blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0: decode = 7'h3F;
         4'd1: decode = 7'h06;
         4'd2: decode = 7'h5B;
         4'd3: decode = 7'h4F;
         4'd4: decode = 7'h66;
         4'd5: decode = 7'h6D;
         4'd6: decode = 7'h7D;
         4'd7: decode = 7'h07;
         4'd8: decode = 7'h7F;
         4'd9: decode = 7'h6F;
         default: decode = 7'h00;
      endcase
   endfunction

   // Add-3 correction applied before each shift
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         r_bcd      <= '0;
         r_bcd_disp <= '0;
         r_last_q   <= '0;
         r_iter     <= '0;
         r_force    <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_force || (q != r_last_q)) begin
                  r_shreg  <= q;
                  r_last_q <= q;
                  r_bcd    <= '0;
                  r_iter   <= '0;
                  r_force  <= 1'b0;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               {r_bcd, r_shreg} <= {w_bcd_adj[BW-2:0], r_shreg, 1'b0};
               r_iter           <= r_iter + 1'b1;
               if (r_iter == IW'(N - 1))
                  r_state <= DONE;
            end
            DONE: begin
               r_bcd_disp <= r_bcd;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = (r_state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (r_div == DW'(SCAN_DIV - 1)) begin
         r_div <= '0;
         r_idx <= (r_idx == XW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // w_zero_hi[i]: digit i and every digit above it are zero
   always_comb begin
      w_zero_hi = '0;
      w_zero_hi[DIGITS-1] = (r_bcd_disp[4*(DIGITS-1) +: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--)
         w_zero_hi[i] = (r_bcd_disp[4*i +: 4] == 4'd0) && w_zero_hi[i+1];
   end

   always_comb begin
      w_nib   = 4'd0;
      w_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == XW'(i)) begin
            w_nib   = r_bcd_disp[4*i +: 4];
            w_blank = (i > 0) && w_zero_hi[i];
         end
      end
   end

   assign seg = w_blank ? 7'h00 : decode(w_nib);
   assign an  = DIGITS'(1) << r_idx;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver: conversion latency, busy window,
// scan order/dwell, blanking, mid-conversion change and reset abort.
module tb_count_display_driver;

   localparam int N        = 8;
   localparam int DIGITS   = 3;
   localparam int SCAN_DIV = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      q;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   count_display_driver #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .reset(reset), .q(q), .seg(seg), .an(an), .busy(busy)
   );

   always #5 clk = ~clk;

   // posedges since reset released: drives the expected scan position
   always @(posedge clk) begin
      if (!reset) ncyc <= 0;
      else        ncyc <= ncyc + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int seg_of(input int v, input int idx);
      int tbl [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
      int p = 1;
      for (int i = 0; i < idx; i++) p = p * 10;
      if (idx > 0 && v < p) return 0;
      return tbl[(v / p) % 10];
   endfunction

   task automatic chk_disp(input int v);
      int idx = (ncyc / SCAN_DIV) % DIGITS;
      chk("an", int'(an), 1 << idx);
      chk("seg", int'(seg), seg_of(v, idx));
   endtask

   // q already changed while idle; next posedge samples it
   task automatic run_conv(input int oldv, input int newv);
      repeat (N + 1) begin
         @(negedge clk);
         chk("busy_hi", int'(busy), 1);
         chk_disp(oldv);
      end
      @(negedge clk);
      chk("busy_lo", int'(busy), 0);
      chk_disp(newv);
   endtask

   task automatic hold(input int v, input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         chk("idle", int'(busy), 0);
         chk_disp(v);
      end
   endtask

   initial begin
      reset = 1'b0;
      q     = '0;
      repeat (2) @(negedge clk);
      chk("rst_seg", int'(seg), 'h3F);
      chk("rst_an", int'(an), 1);
      chk("rst_busy", int'(busy), 0);

      reset = 1'b1;                 // forced conversion of 0
      run_conv(0, 0);
      hold(0, 6);

      q = 8'd255; run_conv(0, 255);
      hold(255, 2 * DIGITS * SCAN_DIV);

      q = 8'd7;   run_conv(255, 7);
      hold(7, DIGITS * SCAN_DIV);

      q = 8'd100; run_conv(7, 100);
      hold(100, DIGITS * SCAN_DIV);

      q = 8'd255; run_conv(100, 255);
      q = 8'd0;   run_conv(255, 0);
      hold(0, DIGITS * SCAN_DIV);
      q = 8'd255; run_conv(0, 255);

      // change q on the 3rd SHIFT cycle: 10 shown first, then 20
      q = 8'd10;
      repeat (3) begin
         @(negedge clk);
         chk("mid_busy", int'(busy), 1);
         chk_disp(255);
      end
      q = 8'd20;
      repeat (N - 2) begin
         @(negedge clk);
         chk("mid_busy", int'(busy), 1);
         chk_disp(255);
      end
      @(negedge clk);
      chk("mid_lo", int'(busy), 0);
      chk_disp(10);
      run_conv(10, 20);
      hold(20, DIGITS * SCAN_DIV);

      // reset abort mid-conversion
      q = 8'd123;
      repeat (3) @(negedge clk);
      chk("abort_busy_pre", int'(busy), 1);
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_seg", int'(seg), 'h3F);
      chk("abort_an", int'(an), 1);
      @(negedge clk);
      reset = 1'b1;
      run_conv(0, 123);
      hold(123, 2 * DIGITS * SCAN_DIV);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
